// File: rtl/printer_pkg.sv
// Shared definitions for the office printer: user grant codes, engine states
// and the grant-code to one-hot completion mapping.
package printer_pkg;

  typedef logic [1:0] user_t;

  localparam user_t USER_NONE = 2'b00;
  localparam user_t USER_BOSS = 2'b01;
  localparam user_t USER_ENG  = 2'b10;
  localparam user_t USER_BOY  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_PRINT,
    S_DONE
  } eng_state_t;

  function automatic logic [2:0] done_onehot(input user_t user);
    case (user)
      USER_BOSS: return 3'b001;
      USER_ENG:  return 3'b010;
      USER_BOY:  return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/printer_engine_if.sv
// Job/status bundle between the requester side and printer_engine.
// abort/aborted exist only when PRINTER_ABORT_EN is defined.
interface printer_engine_if #(
  parameter int PAGE_W = 8
);
  import printer_pkg::*;

  user_t             grant;
  logic [PAGE_W-1:0] job_pages;
  logic              busy;
  user_t             cur_user;
  logic [PAGE_W-1:0] pages_left;
  logic              page_tick;
  logic [2:0]        done;
  logic              job_err;
`ifdef PRINTER_ABORT_EN
  logic              abort;
  logic              aborted;

  modport master (
    output grant, job_pages, abort,
    input  busy, cur_user, pages_left, page_tick, done, job_err, aborted
  );
  modport slave (
    input  grant, job_pages, abort,
    output busy, cur_user, pages_left, page_tick, done, job_err, aborted
  );
`else
  modport master (
    output grant, job_pages,
    input  busy, cur_user, pages_left, page_tick, done, job_err
  );
  modport slave (
    input  grant, job_pages,
    output busy, cur_user, pages_left, page_tick, done, job_err
  );
`endif

endinterface

// File: rtl/printer_timer.sv
// 8-bit loadable down-counter shared by warm-up and page timing; holds at zero.
module printer_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_zero
);

  logic [7:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= 8'd0;
    else if (i_load)           r_count <= i_load_val;
    else if (r_count != 8'd0)  r_count <= r_count - 8'd1;
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/printer_engine.sv
// Printer engine: latches the granted job, times warm-up and pages, pulses done.
// Optional abort support is compiled in with PRINTER_ABORT_EN.
module printer_engine
  import printer_pkg::*;
#(
  parameter int PAGE_W   = 8,
  parameter int WARM_CYC = 4,
  parameter int PAGE_CYC = 8
) (
  input logic              clk,
  input logic              rst_n,
  printer_engine_if.slave  bus
);

  localparam logic [7:0]        WARM_LOAD = 8'(WARM_CYC - 1);
  localparam logic [7:0]        PAGE_LOAD = 8'(PAGE_CYC - 1);
  localparam logic              PAGE_ONE  = 1'(PAGE_CYC == 1);
  localparam logic [PAGE_W-1:0] ONE_PAGE  = PAGE_W'(1);

  eng_state_t        r_state, w_next_state;
  user_t             r_cur_user, w_next_user;
  logic [PAGE_W-1:0] r_pages_left, w_next_pages;
  logic              r_busy, r_page_tick, r_job_err, r_aborted;
  logic [2:0]        r_done;
  logic              w_next_tick, w_next_job_err, w_next_aborted;
  logic [2:0]        w_next_done;
  logic              w_tmr_load, w_tmr_zero, w_abort;
  logic [7:0]        w_tmr_val, w_tmr_count;

`ifdef PRINTER_ABORT_EN
  assign w_abort     = bus.abort;
  assign bus.aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  printer_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  // page_tick and the page decrement are issued on the edge where the timer
  // reaches zero, so the tick is visible during the last cycle of the page.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    w_next_state   = r_state;
    w_next_user    = r_cur_user;
    w_next_pages   = r_pages_left;
    w_next_tick    = 1'b0;
    w_next_done    = 3'b000;
    w_next_job_err = 1'b0;
    w_next_aborted = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_val      = PAGE_LOAD;

    case (r_state)
      S_IDLE: begin
        w_next_user = USER_NONE;
        if (bus.grant != USER_NONE) begin
          if (bus.job_pages != '0) begin
            w_next_state = S_WARMUP;
            w_next_user  = bus.grant;
            w_next_pages = bus.job_pages;
            w_tmr_load   = 1'b1;
            w_tmr_val    = WARM_LOAD;
          end else begin
            w_next_job_err = 1'b1;
          end
        end
      end
      S_WARMUP, S_PRINT: begin
        if (w_abort) begin
          w_next_state   = S_IDLE;
          w_next_user    = USER_NONE;
          w_next_pages   = '0;
          w_next_aborted = 1'b1;
        end else if (w_tmr_zero) begin
          if (r_state == S_PRINT && r_pages_left == '0) begin
            w_next_state = S_DONE;
            w_next_done  = done_onehot(r_cur_user);
          end else begin
            w_next_state = S_PRINT;
            w_tmr_load   = 1'b1;
            if (PAGE_ONE) begin
              w_next_tick  = 1'b1;
              w_next_pages = r_pages_left - ONE_PAGE;
            end
          end
        end else if (r_state == S_PRINT && w_tmr_count == 8'd1) begin
          w_next_tick  = 1'b1;
          w_next_pages = r_pages_left - ONE_PAGE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_user  = USER_NONE;
        w_next_pages = '0;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_user   <= USER_NONE;
      r_pages_left <= '0;
      r_busy       <= 1'b0;
      r_page_tick  <= 1'b0;
      r_done       <= 3'b000;
      r_job_err    <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cur_user   <= w_next_user;
      r_pages_left <= w_next_pages;
      r_busy       <= (w_next_state != S_IDLE);
      r_page_tick  <= w_next_tick;
      r_done       <= w_next_done;
      r_job_err    <= w_next_job_err;
      r_aborted    <= w_next_aborted;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.cur_user   = r_cur_user;
  assign bus.pages_left = r_pages_left;
  assign bus.page_tick  = r_page_tick;
  assign bus.done       = r_done;
  assign bus.job_err    = r_job_err;

endmodule

// File: tb/tb_printer_engine.sv
// Directed self-checking bench for printer_engine (WARM_CYC=2, PAGE_CYC=3).
// Abort scenario is exercised only when PRINTER_ABORT_EN is defined.
module tb_printer_engine;
  import printer_pkg::*;

  localparam int PAGE_W   = 8;
  localparam int WARM_CYC = 2;
  localparam int PAGE_CYC = 3;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  printer_engine_if #(.PAGE_W(PAGE_W)) bus ();

  printer_engine #(
    .PAGE_W   (PAGE_W),
    .WARM_CYC (WARM_CYC),
    .PAGE_CYC (PAGE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_user"},  32'(bus.cur_user), 0);
    check({tag, "_pages"}, 32'(bus.pages_left), 0);
    check({tag, "_tick"},  32'(bus.page_tick), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_err"},   32'(bus.job_err), 0);
  endtask

  initial begin
    int ticks;
    int done_cnt;
    int done_m;
    int stray_done;
    logic wrap;
    logic [PAGE_W-1:0] prev_pages;

    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
`ifdef PRINTER_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset values
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boss, 2 pages: busy m=1..9, ticks m=5,8, done=001 at m=9
    bus.grant     = USER_BOSS;
    bus.job_pages = 8'd2;
    step();
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
    for (int m = 1; m <= 10; m++) begin
      if (m > 1) step();
      check($sformatf("j1_busy_m%0d", m), 32'(bus.busy), 32'(m <= 9));
      check($sformatf("j1_tick_m%0d", m), 32'(bus.page_tick), 32'(m == 5 || m == 8));
      check($sformatf("j1_done_m%0d", m), 32'(bus.done), (m == 9) ? 32'h1 : 32'h0);
      check($sformatf("j1_user_m%0d", m), 32'(bus.cur_user), (m <= 9) ? 32'h1 : 32'h0);
    end
    check("j1_pages_end", 32'(bus.pages_left), 0);

    // Zero-page request from boy: job_err repeats, no job
    bus.grant     = USER_BOY;
    bus.job_pages = '0;
    step();
    check("zp_err1",  32'(bus.job_err), 1);
    check("zp_busy1", 32'(bus.busy), 0);
    check("zp_done1", 32'(bus.done), 0);
    step();
    check("zp_err2",  32'(bus.job_err), 1);
    check("zp_user2", 32'(bus.cur_user), 0);
    bus.grant = USER_NONE;
    step();
    check("zp_err_clr", 32'(bus.job_err), 0);

    // Engineer job, grant switches to boss mid-PRINT
    bus.grant     = USER_ENG;
    bus.job_pages = 8'd1;
    step();
    step();
    step();
    bus.grant     = USER_BOSS;
    bus.job_pages = 8'd1;
    step();
    check("sw_user_m4",  32'(bus.cur_user), 32'(USER_ENG));
    check("sw_pages_m4", 32'(bus.pages_left), 1);
    step();
    check("sw_tick_m5",  32'(bus.page_tick), 1);
    check("sw_pages_m5", 32'(bus.pages_left), 0);
    step();
    check("sw_done_m6",  32'(bus.done), 32'h2);
    step();
    check("sw_busy_m7",  32'(bus.busy), 0);
    check("sw_user_m7",  32'(bus.cur_user), 0);
    check("sw_done_m7",  32'(bus.done), 0);
    step();
    check("sw_busy_m8",  32'(bus.busy), 1);
    check("sw_user_m8",  32'(bus.cur_user), 32'(USER_BOSS));
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
    done_m = 0;
    for (int m = 9; m <= 20; m++) begin
      step();
      if (bus.done != 3'b000 && done_m == 0) begin
        done_m = m;
        check("sw_boss_done", 32'(bus.done), 32'h1);
      end
    end
    check("sw_boss_latency", done_m, 13);

    // Reset mid-PRINT: immediate reset values, no done afterwards
    bus.grant     = USER_BOY;
    bus.job_pages = 8'd3;
    step();
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
    step();
    step();
    step();
    check("rst_pre_busy", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    stray_done = 0;
    for (int m = 0; m < 20; m++) begin
      step();
      if (bus.done != 3'b000 || bus.busy) stray_done++;
    end
    check("rst_no_done", stray_done, 0);

    // 255-page job: 255 ticks, no wrap, single done at W+255*P+1
    bus.grant     = USER_ENG;
    bus.job_pages = 8'd255;
    step();
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
    check("big_pages_m1", 32'(bus.pages_left), 255);
    ticks = 0;
    done_cnt = 0;
    done_m = 0;
    wrap = 1'b0;
    prev_pages = bus.pages_left;
    for (int m = 2; m <= 800; m++) begin
      step();
      if (bus.page_tick) ticks++;
      if (bus.done != 3'b000) begin
        done_cnt++;
        done_m = m;
      end
      if (bus.pages_left > prev_pages) wrap = 1'b1;
      prev_pages = bus.pages_left;
    end
    check("big_ticks",   ticks, 255);
    check("big_done_n",  done_cnt, 1);
    check("big_done_m",  done_m, WARM_CYC + 255 * PAGE_CYC + 1);
    check("big_no_wrap", 32'(wrap), 0);
    check("big_pages_0", 32'(bus.pages_left), 0);
    check("big_idle",    32'(bus.busy), 0);

`ifdef PRINTER_ABORT_EN
    // Abort during WARMUP
    bus.grant     = USER_BOSS;
    bus.job_pages = 8'd4;
    step();
    bus.grant     = USER_NONE;
    bus.job_pages = '0;
    check("ab_busy_pre", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_aborted", 32'(bus.aborted), 1);
    check("ab_busy",    32'(bus.busy), 0);
    check("ab_user",    32'(bus.cur_user), 0);
    check("ab_pages",   32'(bus.pages_left), 0);
    stray_done = 0;
    for (int m = 0; m < 20; m++) begin
      step();
      if (bus.done != 3'b000) stray_done++;
      if (m == 0) check("ab_pulse_clr", 32'(bus.aborted), 0);
    end
    check("ab_no_done", stray_done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/printer_engine.md
# printer_engine

Printer-side engine for the shared office printer. It consumes the 2-bit grant code produced by the round-robin printer arbiter (00 none, 01 boss, 10 engineer, 11 boy) and latches the granted user's job. It then runs warm-up and per-page print timing, and returns a one-hot completion pulse to the winning requester so that requester drops its request.

## Interface
Parameters:
- PAGE_W, 8: width of page count and pages_left.
- WARM_CYC, 4: warm-up cycles per job; legal range 1..255.
- PAGE_CYC, 8: cycles per printed page; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- grant  in  2  arbiter grant code: 00 none, 01 boss, 10 eng, 11 boy.
- job_pages  in  PAGE_W  page count of the granted user's job; sampled at job start.
- abort  in  1  terminate the current job; present only with PRINTER_ABORT_EN.
- busy  out  1  high in every state except IDLE.
- cur_user  out  2  latched grant code of the job in progress; 00 in IDLE.
- pages_left  out  PAGE_W  pages still to print.
- page_tick  out  1  one-cycle pulse on the last cycle of each page.
- done  out  3  one-hot completion pulse: bit0 boss, bit1 eng, bit2 boy.
- job_err  out  1  one-cycle pulse when a zero-page job is rejected.
- aborted  out  1  one-cycle pulse when a job is aborted; present only with PRINTER_ABORT_EN.

## Operation
- FSM states: IDLE, WARMUP, PRINT, DONE. Reset enters IDLE.
- Reset values: busy 0, cur_user 00, pages_left 0, page_tick 0, done 000, job_err 0, aborted 0, internal timer 0.
- IDLE, start condition (grant != 00 and job_pages != 0):
  - latch cur_user = grant and pages_left = job_pages;
  - load timer with WARM_CYC-1;
  - next state WARMUP.
- IDLE, zero-page request (grant != 00 and job_pages == 0): pulse job_err for one cycle and stay in IDLE. The rejected job_err pulse repeats every cycle while the condition holds.
- IDLE, grant == 00: stay in IDLE.
- WARMUP: timer decrements each cycle. When the timer reaches 0, load timer with PAGE_CYC-1 and go to PRINT.
- PRINT: timer decrements each cycle. When the timer reaches 0:
  - page_tick = 1 and pages_left decrements on the same edge;
  - if pages_left was 1, go to DONE;
  - otherwise reload timer with PAGE_CYC-1.
- DONE, one cycle:
  - done[cur_user-1] = 1 and pages_left = 0;
  - next state IDLE; cur_user clears to 00 on entry to IDLE.
- Grant and job_pages are ignored outside IDLE. Jobs are non-preemptive: grant changes mid-job do not affect the latched user.
- A new job can start on the first IDLE cycle after DONE. There is no dead cycle beyond DONE.
- Asynchronous reset mid-job: immediate return to IDLE with all outputs at reset values. No done pulse is issued for the lost job.

## Timing
- Start sampled on edge k:
  - WARMUP occupies cycles k+1 .. k+WARM_CYC;
  - PRINT occupies k+WARM_CYC+1 .. k+WARM_CYC+N*PAGE_CYC, where N = job_pages;
  - DONE (done pulse) occurs at cycle k+WARM_CYC+N*PAGE_CYC+1.
- page_tick occurs at PRINT cycles k+WARM_CYC+i*PAGE_CYC for i = 1..N.
- All outputs are registered; none depend combinationally on inputs.
- Done pulse latency equals WARM_CYC + N*PAGE_CYC + 1 cycles after the start edge.
- A job with job_pages = 2^PAGE_W-1 must complete without wrap. pages_left never underflows.

## Configuration
- PRINTER_ABORT_EN defined:
  - the abort input and aborted output exist;
  - abort high in WARMUP or PRINT causes the next state to be IDLE, pulses aborted for one cycle, and clears pages_left and cur_user;
  - no done pulse is issued;
  - abort in IDLE or DONE is ignored, and DONE completes normally.
- PRINTER_ABORT_EN undefined: neither port exists, and the behaviour is identical to abort tied 0.

## Structure
- Shared package printer_pkg contains:
  - user code constants USER_NONE=2'b00, USER_BOSS=2'b01, USER_ENG=2'b10, USER_BOY=2'b11;
  - the engine state enum; the arbiter and this engine both import it.
- One sub-module, printer_timer: 8-bit loadable down-counter with a load input, a load value, and a zero flag. It is shared by warm-up and page timing.

## Test plan
- Reset, then grant=01 with job_pages=2, WARM_CYC=2, PAGE_CYC=3 -> busy high for 9 cycles, page_tick at start+5 and start+8, done=001 at start+9, cur_user returns to 00.
- grant=11 with job_pages=0 in IDLE -> job_err pulses, busy stays 0, done stays 000.
- Grant switches 10→01 mid-PRINT -> job continues for eng, done=010, and the boss job starts on the first IDLE cycle.
- rst_n low mid-PRINT -> outputs go to reset values immediately, and no done pulse follows release.
- job_pages=255 -> exactly 255 page_ticks, pages_left reaches 0 with no wrap, done asserted once.
- With PRINTER_ABORT_EN, abort during WARMUP -> aborted pulses, IDLE next cycle, done stays 000.
